// File: rtl/block_acc_pkg.sv
// block_accumulator shared types and width helper.
// Optional clear port is enabled by defining BLOCK_ACC_CLEAR_EN.
package block_acc_pkg;

    // Output slot occupancy; SLOT_FULL is exactly sum_valid.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // A block of 2^div_log2 samples needs div_log2 extra bits.
    function automatic int acc_width(input int out_w, input int div_log2);
        return out_w + div_log2;
    endfunction

endpackage

// File: rtl/block_acc_if.sv
// Sample input and block-total output handshakes.
// Used by block_accumulator (BLOCK_ACC_CLEAR_EN adds a separate clear port).
interface block_acc_if #(
    parameter int OUT_WIDTH = 32,
    parameter int IN_WIDTH  = 35
);
    logic [OUT_WIDTH-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic [IN_WIDTH-1:0]  sum;
    logic                 sum_valid;
    logic                 sum_ready;

    modport slave (
        input  din, din_valid, sum_ready,
        output din_ready, sum, sum_valid
    );

    modport master (
        output din, din_valid, sum_ready,
        input  din_ready, sum, sum_valid
    );
endinterface

// File: rtl/block_acc_out_slot.sv
// Single-entry valid/ready register for completed block totals.
// Part of block_accumulator (clear option BLOCK_ACC_CLEAR_EN never touches it).
module block_acc_out_slot
    import block_acc_pkg::*;
#(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    slot_state_e  state_q, state_d;
    logic [W-1:0] data_q, data_d;

    // A load wins over a drain: the caller only loads when the slot is
    // empty or draining this cycle, so the new total simply replaces it.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            state_d = SLOT_FULL;
            data_d  = data_i;
        end else if (state_q == SLOT_FULL && ready_i) begin
            state_d = SLOT_EMPTY;
        end
    end

    // Slot register; data holds steady while full and not drained.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign full_o = (state_q == SLOT_FULL);
    assign data_o = data_q;

endmodule

// File: rtl/block_accumulator.sv
// Sums non-overlapping blocks of 2^DIV_LOG2 samples for the divider.
// Define BLOCK_ACC_CLEAR_EN to add the clear port (drops a partial block).
module block_accumulator
    import block_acc_pkg::*;
#(
    parameter int DIV_LOG2  = 3,
    parameter int OUT_WIDTH = 32,
    parameter int IN_WIDTH  = acc_width(OUT_WIDTH, DIV_LOG2)
) (
    input  logic clk,
    input  logic resetn,
`ifdef BLOCK_ACC_CLEAR_EN
    input  logic clear,
`endif
    block_acc_if.slave bus
);

    localparam logic [DIV_LOG2-1:0] CNT_LAST = '1;

    logic [IN_WIDTH-1:0] acc_q, acc_d;
    logic [IN_WIDTH-1:0] total;
    logic [DIV_LOG2-1:0] cnt_q, cnt_d;
    logic                last;
    logic                full;
    logic                din_ready_w;
    logic                accept;
    logic                load;
    logic                clr;

`ifdef BLOCK_ACC_CLEAR_EN
    assign clr = clear;
`else
    assign clr = 1'b0;
`endif

    assign last        = (cnt_q == CNT_LAST);
    assign din_ready_w = !(last && full && !bus.sum_ready);
    assign accept      = bus.din_valid && din_ready_w;
    assign total       = acc_q + IN_WIDTH'(bus.din);

    assign bus.din_ready = din_ready_w;
    assign bus.sum_valid = full;

    // Next accumulator/count; clear overrides even a completing sample.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        load  = 1'b0;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
                load  = 1'b1;
            end else begin
                acc_d = total;
                cnt_d = cnt_q + DIV_LOG2'(1);
            end
        end
    end

    // Running partial sum and position within the block.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    block_acc_out_slot #(
        .W (IN_WIDTH)
    ) u_slot (
        .clk     (clk),
        .resetn  (resetn),
        .load_i  (load),
        .data_i  (total),
        .ready_i (bus.sum_ready),
        .full_o  (full),
        .data_o  (bus.sum)
    );

endmodule

// File: tb/tb_block_accumulator.sv
// Directed and random checks of block_accumulator against a block-sum model.
// Define BLOCK_ACC_CLEAR_EN to also exercise the clear port.
module tb_block_accumulator;

    localparam int DIV_LOG2  = 3;
    localparam int OUT_WIDTH = 32;
    localparam int IN_WIDTH  = 35;
    localparam int N         = 8;

    logic clk = 1'b0;
    logic resetn;
`ifdef BLOCK_ACC_CLEAR_EN
    logic clear;
`endif

    block_acc_if #(.OUT_WIDTH(OUT_WIDTH), .IN_WIDTH(IN_WIDTH)) bus ();

    block_accumulator #(
        .DIV_LOG2  (DIV_LOG2),
        .OUT_WIDTH (OUT_WIDTH),
        .IN_WIDTH  (IN_WIDTH)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
`ifdef BLOCK_ACC_CLEAR_EN
        .clear  (clear),
`endif
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: samples of the current block, and the pending total if any.
    longint unsigned blk[$];
    bit              pend;
    longint unsigned pend_val;
    int              n_out;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        blk.delete();
        pend     = 1'b0;
        pend_val = 0;
    endtask

    // One clock: starts just after a negedge, ends at the next negedge.
    task automatic cycle(input logic [31:0] d, input bit v, input bit r,
                         input bit c, output bit taken);
        bit              exp_rdy;
        longint unsigned s;
        bus.din       = d;
        bus.din_valid = v;
        bus.sum_ready = r;
`ifdef BLOCK_ACC_CLEAR_EN
        clear = c;
`endif
        exp_rdy = !(blk.size() == N - 1 && pend && !r);
        #1;
        check("din_ready", bus.din_ready, exp_rdy);
        taken = v && exp_rdy;
        if (pend && r) begin
            pend = 1'b0;
            n_out++;
        end
        if (c) begin
            blk.delete();
        end else if (taken) begin
            blk.push_back(longint'(d));
            if (blk.size() == N) begin
                s = 0;
                foreach (blk[i]) s += blk[i];
                pend     = 1'b1;
                pend_val = s;
                blk.delete();
            end
        end
        @(negedge clk);
        check("sum_valid", bus.sum_valid, pend);
        if (pend) check("sum", bus.sum, pend_val);
    endtask

    task automatic step(input logic [31:0] d, input bit v, input bit r);
        bit t;
        cycle(d, v, r, 1'b0, t);
    endtask

    initial begin
        int  accepted;
        int  base;
        bit  t;

        resetn        = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.sum_ready = 1'b0;
`ifdef BLOCK_ACC_CLEAR_EN
        clear = 1'b0;
`endif
        model_reset();
        n_out = 0;
        #1;
        check("rst_sum_valid", bus.sum_valid, 1'b0);
        check("rst_sum", bus.sum, 0);
        check("rst_din_ready", bus.din_ready, 1'b1);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Samples 1..8 back-to-back.
        for (int i = 1; i <= 8; i++) step(i, 1'b1, 1'b1);
        check("t1_valid", bus.sum_valid, 1'b1);
        check("t1_total", bus.sum, 36);
        step(0, 1'b0, 1'b1);
        check("t1_one_cycle", bus.sum_valid, 1'b0);

        // Largest samples, then zeros.
        for (int i = 0; i < 8; i++) step(32'hFFFF_FFFF, 1'b1, 1'b1);
        check("t2_max", bus.sum, 35'h7_FFFF_FFF8);
        for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b1);
        check("t2_zero_valid", bus.sum_valid, 1'b1);
        check("t2_zero", bus.sum, 0);
        step(0, 1'b0, 1'b1);

        // Backpressure: 16th sample must stall until the slot drains.
        for (int i = 0; i < 15; i++) step(2, 1'b1, 1'b0);
        check("t3_first", bus.sum, 16);
        for (int i = 0; i < 2; i++) begin
            cycle(2, 1'b1, 1'b0, 1'b0, t);
            check("t3_stall_taken", t, 1'b0);
            check("t3_stall_rdy", bus.din_ready, 1'b0);
            check("t3_held", bus.sum, 16);
        end
        cycle(2, 1'b1, 1'b1, 1'b0, t);
        check("t3_release_taken", t, 1'b1);
        check("t3_second_valid", bus.sum_valid, 1'b1);
        check("t3_second", bus.sum, 16);
        step(0, 1'b0, 1'b1);

        // Random stream of 64 samples with random backpressure.
        accepted = 0;
        base     = n_out;
        for (int k = 0; k < 2000 && accepted < 64; k++) begin
            cycle($urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, 1'b0, t);
            if (t) accepted++;
        end
        check("t4_accepted", accepted, 64);
        repeat (3) step(0, 1'b0, 1'b1);
        check("t4_totals", n_out - base, 8);

        // Reset mid-block with a total pending.
        for (int i = 0; i < 8; i++) step(3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1, 1'b1, 1'b0);
        check("t5_pending", bus.sum, 24);
        bus.din_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("t5_rst_valid", bus.sum_valid, 1'b0);
        check("t5_rst_sum", bus.sum, 0);
        check("t5_rst_rdy", bus.din_ready, 1'b1);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) step(1, 1'b1, 1'b1);
        check("t5_after", bus.sum, 8);
        step(0, 1'b0, 1'b1);

`ifdef BLOCK_ACC_CLEAR_EN
        // Clear drops the partial block but keeps a pending total.
        for (int i = 0; i < 8; i++) step(5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(10, 1'b1, 1'b0);
        cycle(7, 1'b1, 1'b0, 1'b1, t);
        check("t6_kept_valid", bus.sum_valid, 1'b1);
        check("t6_kept", bus.sum, 40);
        for (int i = 0; i < 8; i++) step(1, 1'b1, 1'b1);
        check("t6_after", bus.sum, 8);
        step(0, 1'b0, 1'b1);
        // Clear beats the completing sample.
        for (int i = 0; i < 7; i++) step(4, 1'b1, 1'b1);
        cycle(9, 1'b1, 1'b1, 1'b1, t);
        check("t6_no_total", bus.sum_valid, 1'b0);
        for (int i = 0; i < 8; i++) step(1, 1'b1, 1'b1);
        check("t6_after2", bus.sum, 8);
        step(0, 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_accumulator.md
# block_accumulator

Upstream feeder for the rounding divider. Accepts a stream of unsigned OUT_WIDTH-bit samples and sums each non-overlapping block of 2^DIV_LOG2 samples into an IN_WIDTH-bit total. Each completed total is presented on a valid/ready output, and its width matches the divider's `din`. An internal output slot decouples accumulation from downstream backpressure, so the next block accumulates while the previous total waits.

## Interface
- DIV_LOG2, 3, log2 of block length N = 2^DIV_LOG2 (≥1)
- OUT_WIDTH, 32, sample width
- IN_WIDTH, OUT_WIDTH+DIV_LOG2, total width; must not be overridden smaller
- clk  input  1  clock, all logic on rising edge
- resetn  input  1  asynchronous active-low reset
- din  input  OUT_WIDTH  unsigned sample
- din_valid  input  1  sample present
- din_ready  output  1  block can take a sample this cycle
- sum  output  IN_WIDTH  completed block total
- sum_valid  output  1  sum holds an unconsumed total
- sum_ready  input  1  downstream accepts sum
- clear  input  1  only with BLOCK_ACC_CLEAR_EN: discard partial block

## Operation
- Sample accepted when din_valid && din_ready.
- State: acc (IN_WIDTH), cnt (DIV_LOG2 bits, 0..N-1), output slot (sum, sum_valid).
- Arithmetic is unsigned. N·(2^OUT_WIDTH−1) fits in IN_WIDTH, so no overflow and no saturation.
- Accept with cnt < N−1: acc ← acc + din; cnt ← cnt + 1.
- Accept with cnt == N−1 (last sample): sum ← acc + din; sum_valid ← 1; acc ← 0; cnt ← 0 (wraps).
- Output accepted when sum_valid && sum_ready. On acceptance, sum_valid ← 0 unless a new last sample is accepted in the same cycle; in that case sum loads the new total and sum_valid stays 1.
- din_ready = !(cnt == N−1 && sum_valid && !sum_ready).
  - Only the completing sample stalls, and only while the slot is full and not draining.
  - Non-final samples are always accepted.
- din is ignored when din_valid is low. sum is stable while sum_valid && !sum_ready.

## Timing
- Reset (async assert, sync-safe deassert): acc = 0, cnt = 0, sum = 0, sum_valid = 0, din_ready = 1.
- Latency: sum_valid rises the cycle after the Nth sample of a block is accepted.
- Throughput: one sample per cycle sustained when sum_ready is held high. One total per N cycles.
- Reset mid-block: the partial sum and any pending total are lost. The first block after reset starts at cnt = 0.
- din_ready is combinational from cnt, sum_valid and sum_ready. No combinational path from din_valid to din_ready, or from sum_ready to sum_valid.

## Configuration
- BLOCK_ACC_CLEAR_EN defined: the `clear` port exists.
  - clear high: acc ← 0 and cnt ← 0 next cycle; any sample accepted in that cycle is discarded.
  - The output slot is not affected: a pending sum remains valid until consumed.
  - clear has priority over accumulation, including over completion of a block.
- BLOCK_ACC_CLEAR_EN undefined: no `clear` port; a partial block is discarded only by reset.

## Structure
- Shared package block_acc_pkg:
  - function clog2-free width check, `acc_width(out_w, div_log2)` returning out_w + div_log2
  - typedef for the slot state enum {SLOT_EMPTY, SLOT_FULL}, which mirrors sum_valid
- One sub-module: block_acc_out_slot.
  - Single-entry valid/ready register holding sum and sum_valid.
  - Exposes a load strobe and a full indicator to the accumulator.
- The accumulator counter stays in the top module. Total RTL is roughly 150–250 lines.

## Test plan
All scenarios use DIV_LOG2 = 3 and OUT_WIDTH = 32 (IN_WIDTH = 35).
- Samples 1..8 back-to-back, sum_ready = 1 → sum = 36 with sum_valid for one cycle, asserted one cycle after the 8th sample.
- Eight samples of 0xFFFF_FFFF → sum = 0x7_FFFF_FFF8, no wrap. A following block of 0s → sum = 0.
- sum_ready = 0, 16 samples of value 2 streamed:
  - first sum = 16 held stable
  - din_ready drops on the 16th sample while cnt = 7
  - raise sum_ready → first total consumed and the 16th sample accepted in the same cycle, so the next cycle presents the second total of 16
- Continuous 64-sample stream with random sum_ready → the scoreboard matches every block total in order, with no lost or duplicated totals.
- Assert resetn low after 5 samples → outputs return to reset values immediately. The next 8 samples of 1 → sum = 8.
- With BLOCK_ACC_CLEAR_EN: 3 samples of 10, clear, then 8 samples of 1 → sum = 8. A pending sum present at clear time survives.
